link_align_ctrl: RTL and testbench

Sequencer for the per-link word aligner in the link-capture path. It drives the aligner's search enable and qualifies the aligner's `match` strobe. It declares lock only after a run of correctly spaced matches, then freezes the alignment. Downstream word-check results can drop it back to search, and a search that runs too long ends in a fail state.

---
 rtl/link_align_ctrl.sv | 147 ++++++++++++++
 tb/tb_link_align_ctrl.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/link_align_ctrl.sv
// link_align_ctrl: sequencer for the per-link word aligner.
// It drives the aligner search enable, qualifies correctly spaced match
// strobes into a lock decision, tracks downstream word errors while locked,
// and bounds the time spent searching with a fail state.
module link_align_ctrl #(
  parameter int PERIOD       = 4,
  parameter int LOCK_COUNT   = 8,
  parameter int UNLOCK_COUNT = 4,
  parameter int BLANK        = 3,
  parameter int TIMEOUT      = 16000
) (
  input  logic       clk160,
  input  logic       rstb,
  input  logic       start,
  input  logic       stop,
  input  logic       match,
  input  logic       word_ok,
  input  logic       word_err,
  output logic       en,
  output logic       locked,
  output logic       fail,
  output logic       busy,
  output logic [2:0] state,
  output logic [7:0] relock_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_BLANK  = 3'd1,
    S_SEARCH = 3'd2,
    S_LOCKED = 3'd3,
    S_FAIL   = 3'd4
  } state_t;

  localparam logic [7:0]  GAP_LAST   = 8'(PERIOD - 1);
  localparam logic [7:0]  BLANK_LAST = 8'(BLANK - 1);
  localparam logic [7:0]  LOCK_LIM   = 8'(LOCK_COUNT);
  localparam logic [7:0]  UNLOCK_LIM = 8'(UNLOCK_COUNT);
  localparam logic [23:0] TMO_LIM    = 24'(TIMEOUT);

  state_t      cur, nxt;
  logic [7:0]  blank_cnt, blank_nx;
  logic [7:0]  gap, gap_nx;
  logic [7:0]  good, good_nx;
  logic [7:0]  err_cnt, err_nx;
  logic [23:0] tmo, tmo_nx;
  logic [7:0]  relock_nx;
  logic        enter_blank;

  // Next-state and counter update; every entry into BLANK restarts the search cleanly.
  always_comb begin
    nxt         = cur;
    blank_nx    = blank_cnt;
    gap_nx      = gap;
    good_nx     = good;
    err_nx      = err_cnt;
    tmo_nx      = tmo;
    relock_nx   = relock_count;
    enter_blank = 1'b0;
    case (cur)
      S_IDLE: begin
        if (start) enter_blank = 1'b1;
      end
      S_BLANK: begin
        // match is ignored here while the aligner pipeline flushes
        tmo_nx = tmo + 24'd1;
        if (start)                       enter_blank = 1'b1;
        else if (tmo + 24'd1 == TMO_LIM) nxt = S_FAIL;
        else if (blank_cnt == BLANK_LAST) nxt = S_SEARCH;
        else                             blank_nx = blank_cnt + 8'd1;
      end
      S_SEARCH: begin
        tmo_nx = tmo + 24'd1;
        if (match) begin
          gap_nx = 8'd0;
          // a mis-spaced match is itself the first match of a new run
          if (good == 8'd0 || gap != GAP_LAST) good_nx = 8'd1;
          else                                 good_nx = good + 8'd1;
        end else if (gap == GAP_LAST) begin
          good_nx = 8'd0;
          gap_nx  = 8'd0;
        end else begin
          gap_nx = gap + 8'd1;
        end
        // lock is checked before timeout so a simultaneous lock wins
        if (start)                       enter_blank = 1'b1;
        else if (good == LOCK_LIM)       nxt = S_LOCKED;
        else if (tmo + 24'd1 == TMO_LIM) nxt = S_FAIL;
      end
      S_LOCKED: begin
        if (word_err)     err_nx = err_cnt + 8'd1;
        else if (word_ok) err_nx = 8'd0;
        if (start) begin
          enter_blank = 1'b1;
        end else if (word_err && (err_cnt + 8'd1 == UNLOCK_LIM)) begin
          enter_blank = 1'b1;
          if (relock_count != 8'hFF) relock_nx = relock_count + 8'd1;
        end
      end
      S_FAIL: begin
        if (start) enter_blank = 1'b1;
      end
      default: nxt = S_IDLE;
    endcase
    if (enter_blank) begin
      nxt      = S_BLANK;
      blank_nx = 8'd0;
      gap_nx   = 8'd0;
      good_nx  = 8'd0;
      err_nx   = 8'd0;
      tmo_nx   = 24'd0;
    end
    if (stop) nxt = S_IDLE;
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk160 or negedge rstb) begin
    if (!rstb) begin
      cur          <= S_IDLE;
      blank_cnt    <= 8'd0;
      gap          <= 8'd0;
      good         <= 8'd0;
      err_cnt      <= 8'd0;
      tmo          <= 24'd0;
      relock_count <= 8'd0;
      en           <= 1'b0;
      busy         <= 1'b0;
      locked       <= 1'b0;
      fail         <= 1'b0;
    end else begin
      cur          <= nxt;
      blank_cnt    <= blank_nx;
      gap          <= gap_nx;
      good         <= good_nx;
      err_cnt      <= err_nx;
      tmo          <= tmo_nx;
      relock_count <= relock_nx;
      en           <= (nxt == S_BLANK) || (nxt == S_SEARCH);
      busy         <= (nxt == S_BLANK) || (nxt == S_SEARCH);
      locked       <= (nxt == S_LOCKED);
      fail         <= (nxt == S_FAIL);
    end
  end

  assign state = cur;

endmodule

// File: tb/tb_link_align_ctrl.sv
// tb_link_align_ctrl: directed vectors and hand-written sequences for
// link_align_ctrl with default parameters.
module tb_link_align_ctrl;

  logic       clk160 = 1'b0;
  logic       rstb = 1'b0;
  logic       start = 1'b0, stop = 1'b0, match = 1'b0, word_ok = 1'b0, word_err = 1'b0;
  logic       en, locked, fail, busy;
  logic [2:0] state;
  logic [7:0] relock_count;

  int checks = 0;
  int errors = 0;
  int g[$];

  typedef struct {
    logic       s, p, m, ok, er;
    logic [2:0] st;
    logic       e, l, f, b;
    logic [7:0] rc;
  } vec_t;

  vec_t tbl[9];

  always #5 clk160 = ~clk160;

  link_align_ctrl dut (
    .clk160(clk160), .rstb(rstb), .start(start), .stop(stop), .match(match),
    .word_ok(word_ok), .word_err(word_err), .en(en), .locked(locked),
    .fail(fail), .busy(busy), .state(state), .relock_count(relock_count)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic outs(input string nm, input logic [2:0] st, input logic e, input logic l,
                      input logic f, input logic b, input logic [7:0] rc);
    chk({nm, " state"}, 32'(state), 32'(st));
    chk({nm, " en"}, 32'(en), 32'(e));
    chk({nm, " locked"}, 32'(locked), 32'(l));
    chk({nm, " fail"}, 32'(fail), 32'(f));
    chk({nm, " busy"}, 32'(busy), 32'(b));
    chk({nm, " relock"}, 32'(relock_count), 32'(rc));
  endtask

  // one clock with the given inputs, sampled 1 time unit after the edge
  task automatic cyc(input logic s, input logic p, input logic m, input logic ok, input logic er);
    start = s; stop = p; match = m; word_ok = ok; word_err = er;
    @(posedge clk160); #1;
    start = 0; stop = 0; match = 0; word_ok = 0; word_err = 0;
  endtask

  // called on the cycle BLANK was just entered; walks through the blanking window
  task automatic en_search(input string nm);
    cyc(0, 0, 0, 0, 0); chk({nm, " blank1"}, 32'(state), 32'd1);
    cyc(0, 0, 0, 0, 0); chk({nm, " blank2"}, 32'(state), 32'd1);
    cyc(0, 0, 0, 0, 0); chk({nm, " search"}, 32'(state), 32'd2);
  endtask

  // matches at the edge gaps in g, then expect lock exactly one edge after the last
  task automatic run_gaps(input string nm);
    for (int i = 0; i < g.size(); i++)
      for (int j = 1; j <= g[i]; j++) begin
        cyc(0, 0, (j == g[i]), 0, 0);
        chk({nm, " still searching"}, 32'(state), 32'd2);
      end
    cyc(0, 0, 0, 0, 0);
    chk({nm, " locked"}, 32'(locked), 32'd1);
    chk({nm, " lock state"}, 32'(state), 32'd3);
    chk({nm, " lock en"}, 32'(en), 32'd0);
  endtask

  task automatic lock_clean(input string nm);
    g = '{2, 4, 4, 4, 4, 4, 4, 4};
    run_gaps(nm);
  endtask

  task automatic unlock4(input string nm, input logic [7:0] rc);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1);
      chk({nm, " held"}, 32'(state), 32'd3);
    end
    cyc(0, 0, 0, 0, 1);
    outs(nm, 3'd1, 1, 0, 0, 1, rc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    //          s  p  m ok er  st e  l  f  b  rc
    tbl[0] = '{0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 8'd0};
    tbl[1] = '{1, 0, 0, 0, 0, 3'd1, 1, 0, 0, 1, 8'd0};
    tbl[2] = '{0, 0, 1, 0, 0, 3'd1, 1, 0, 0, 1, 8'd0};
    tbl[3] = '{0, 0, 1, 0, 0, 3'd1, 1, 0, 0, 1, 8'd0};
    tbl[4] = '{0, 0, 0, 0, 0, 3'd2, 1, 0, 0, 1, 8'd0};
    tbl[5] = '{1, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 8'd0};
    tbl[6] = '{0, 0, 0, 0, 0, 3'd0, 0, 0, 0, 0, 8'd0};
    tbl[7] = '{1, 0, 0, 0, 0, 3'd1, 1, 0, 0, 1, 8'd0};
    tbl[8] = '{0, 1, 0, 0, 0, 3'd0, 0, 0, 0, 0, 8'd0};

    // reset
    repeat (2) @(posedge clk160);
    #1;
    outs("reset", 3'd0, 0, 0, 0, 0, 8'd0);
    rstb = 1'b1;

    // table: blank timing, stop+start priority, stop from BLANK
    for (int i = 0; i < 9; i++) begin
      cyc(tbl[i].s, tbl[i].p, tbl[i].m, tbl[i].ok, tbl[i].er);
      outs($sformatf("vec%0d", i), tbl[i].st, tbl[i].e, tbl[i].l, tbl[i].f, tbl[i].b, tbl[i].rc);
    end

    // clean lock: first match at SEARCH cycle 2, lock 29 edges after it
    cyc(1, 0, 0, 0, 0);
    en_search("clean");
    lock_clean("clean");
    chk("clean relock", 32'(relock_count), 32'd0);

    // start while LOCKED restarts without counting a relock
    cyc(1, 0, 0, 0, 0);
    outs("restart", 3'd1, 1, 0, 0, 1, 8'd0);
    en_search("spacing");
    g = '{2, 4, 4, 4, 3, 4, 4, 4, 4, 4, 4, 4};
    run_gaps("spacing");

    // missing match clears the run
    cyc(1, 0, 0, 0, 0);
    en_search("missing");
    g = '{2, 4, 4, 8, 4, 4, 4, 4, 4, 4, 4};
    run_gaps("missing");

    // unlock: word_ok in the middle clears the error run
    for (int i = 0; i < 3; i++) begin
      cyc(0, 0, 0, 0, 1);
      chk("unlock err", 32'(state), 32'd3);
    end
    cyc(0, 0, 0, 1, 0);
    chk("unlock ok", 32'(state), 32'd3);
    unlock4("unlock", 8'd1);

    // simultaneous ok+err counts as an error
    en_search("both");
    lock_clean("both");
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 1);
    chk("both held", 32'(state), 32'd3);
    cyc(0, 0, 0, 1, 1);
    outs("both", 3'd1, 1, 0, 0, 1, 8'd2);

    // timeout: 16000 BLANK+SEARCH cycles with no match
    cyc(0, 1, 0, 0, 0);
    chk("to idle", 32'(state), 32'd0);
    cyc(1, 0, 0, 0, 0);
    for (int i = 1; i < 16000; i++) cyc(0, 0, 0, 0, 0);
    outs("pre timeout", 3'd2, 1, 0, 0, 1, 8'd2);
    cyc(0, 0, 0, 0, 0);
    outs("timeout", 3'd4, 0, 0, 1, 0, 8'd2);
    cyc(0, 0, 0, 0, 0);
    chk("fail sticky", 32'(fail), 32'd1);
    cyc(1, 0, 0, 0, 0);
    outs("fail restart", 3'd1, 1, 0, 0, 1, 8'd2);

    // build relock_count up to 5
    for (int k = 3; k <= 5; k++) begin
      en_search("relock");
      lock_clean("relock");
      unlock4("relock", 8'(k));
    end
    en_search("final");
    lock_clean("final");

    // asynchronous reset mid-lock
    @(posedge clk160); #3;
    rstb = 1'b0;
    #1;
    outs("async reset", 3'd0, 0, 0, 0, 0, 8'd0);
    @(posedge clk160); #1;
    rstb = 1'b1;
    for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0, 0);
    outs("after reset", 3'd0, 0, 0, 0, 0, 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
